// File: rtl/bsg_manycore_pkg.sv
// bsg_manycore_pkg
//   Shared manycore definitions used by the tile-side store issue logic.
//   The package holds the packet op encodings and the fence state enum.
//   Width-parameterized structs cannot live in a package, so this file also
//   defines macros that modules expand with their own widths:
//     DECLARE_BSG_MANYCORE_PACKET_S       manycore packet layout
//     DECLARE_BSG_MANYCORE_STORE_ENTRY_S  queued remote-store request
//     BSG_MANYCORE_PACKET_WIDTH           bit width of that packet layout

`ifndef BSG_MANYCORE_PACKET_MACROS
`define BSG_MANYCORE_PACKET_MACROS

`define BSG_MANYCORE_PACKET_WIDTH(addr_w, data_w, x_w, y_w) \
   ((addr_w) + 2 + ((data_w) >> 3) + (data_w) + 2*(y_w) + 2*(x_w))

`define DECLARE_BSG_MANYCORE_PACKET_S(addr_w, data_w, x_w, y_w) \
   typedef struct packed { \
      logic [(addr_w)-1:0]        addr; \
      logic [1:0]                 op; \
      logic [((data_w)>>3)-1:0]   op_ex; \
      logic [(data_w)-1:0]        payload; \
      logic [(y_w)-1:0]           src_y_cord; \
      logic [(x_w)-1:0]           src_x_cord; \
      logic [(y_w)-1:0]           y_cord; \
      logic [(x_w)-1:0]           x_cord; \
   } bsg_manycore_packet_s

`define DECLARE_BSG_MANYCORE_STORE_ENTRY_S(addr_w, data_w, x_w, y_w) \
   typedef struct packed { \
      logic [(y_w)-1:0]           dest_y; \
      logic [(x_w)-1:0]           dest_x; \
      logic [(addr_w)-1:0]        addr; \
      logic [(data_w)-1:0]        data; \
      logic [((data_w)>>3)-1:0]   mask; \
   } bsg_manycore_store_entry_s

`endif

package bsg_manycore_pkg;

   typedef enum logic [1:0] {
      e_remote_load  = 2'b00,
      e_remote_store = 2'b01,
      e_remote_amo   = 2'b10,
      e_cache_op     = 2'b11
   } bsg_manycore_packet_op_e;

   typedef enum logic [1:0] {
      e_fence_idle         = 2'b00,
      e_fence_drain        = 2'b01,
      e_fence_wait_credits = 2'b10
   } fence_state_e;

endpackage

// File: rtl/bsg_manycore_store_issue_queue.sv
// bsg_manycore_store_issue_queue
//   Circular buffer of els_p entries with a registered storage array.
//   The pointers wrap explicitly at els_p-1, so depths that are not a power
//   of two work as well.
//   Ports:
//     clk_i, reset_n_i   clock, asynchronous active-low reset (pointers only)
//     enq_i, data_i      write one entry at the tail
//     deq_i              retire the head entry
//     data_o             head entry (stable until dequeued)
//     full_o, empty_o    occupancy flags

module bsg_manycore_store_issue_queue
  #(parameter int width_p = 8
   ,parameter int els_p   = 2
   ,localparam int ptr_width_lp   = $clog2(els_p)
   ,localparam int count_width_lp = $clog2(els_p+1)
   )
   (input  logic               clk_i
   ,input  logic               reset_n_i
   ,input  logic               enq_i
   ,input  logic [width_p-1:0] data_i
   ,input  logic               deq_i
   ,output logic [width_p-1:0] data_o
   ,output logic               full_o
   ,output logic               empty_o
   );

   logic [width_p-1:0]        mem_reg [els_p];
   logic [ptr_width_lp-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [ptr_width_lp-1:0]   wr_ptr_next, rd_ptr_next;
   logic [count_width_lp-1:0] count_reg;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(els_p-1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_ptr_next = ptr_inc(wr_ptr_reg);
   assign rd_ptr_next = ptr_inc(rd_ptr_reg);

   // Storage carries no reset: contents are only observed through count_reg.
   always_ff @(posedge clk_i) begin
      if (enq_i)
         mem_reg[wr_ptr_reg] <= data_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end
      else begin
         if (enq_i)
            wr_ptr_reg <= wr_ptr_next;
         if (deq_i)
            rd_ptr_reg <= rd_ptr_next;
         case ({enq_i, deq_i})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign data_o  = mem_reg[rd_ptr_reg];
   assign full_o  = (count_reg == count_width_lp'(els_p));
   assign empty_o = (count_reg == '0);

endmodule

// File: rtl/bsg_manycore_store_issue.sv
// bsg_manycore_store_issue
//   Tile-side remote-store issue stage in front of the endpoint out port.
//   Core stores are queued, formatted into manycore remote-store packets and
//   launched when the endpoint shows a nonzero credit count. A fence blocks
//   new stores until the queue is empty and all credits have come back.
//   Ports:
//     clk_i, reset_n_i                 clock, asynchronous active-low reset
//     v_i, ready_o, dest_*, addr_i,
//     data_i, mask_i                   core store request handshake
//     fence_i                          one-cycle fence request
//     fence_busy_o, fence_done_o       fence status / completion pulse
//     my_x_i, my_y_i                   own coordinates (packet source)
//     out_v_o, out_packet_o,
//     out_ready_i, out_credits_i       endpoint out port
//   Build option BSG_MANYCORE_STORE_ISSUE_STATS_EN adds credit_stall_cnt_o,
//   a saturating count of cycles with a queued store but zero credits.

module bsg_manycore_store_issue
   import bsg_manycore_pkg::*;
  #(parameter int x_cord_width_p    = 4
   ,parameter int y_cord_width_p    = 4
   ,parameter int data_width_p      = 32
   ,parameter int addr_width_p      = 32
   ,parameter int fifo_els_p        = 2
   ,parameter int max_out_credits_p = 4
   ,localparam int credit_width_lp  = $clog2(max_out_credits_p+1)
   ,localparam int packet_width_lp  =
      `BSG_MANYCORE_PACKET_WIDTH(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
   )
   (input  logic                        clk_i
   ,input  logic                        reset_n_i
   ,input  logic                        v_i
   ,input  logic [x_cord_width_p-1:0]   dest_x_i
   ,input  logic [y_cord_width_p-1:0]   dest_y_i
   ,input  logic [addr_width_p-1:0]     addr_i
   ,input  logic [data_width_p-1:0]     data_i
   ,input  logic [data_width_p/8-1:0]   mask_i
   ,output logic                        ready_o
   ,input  logic                        fence_i
   ,output logic                        fence_busy_o
   ,output logic                        fence_done_o
   ,input  logic [x_cord_width_p-1:0]   my_x_i
   ,input  logic [y_cord_width_p-1:0]   my_y_i
   ,output logic                        out_v_o
   ,output logic [packet_width_lp-1:0]  out_packet_o
   ,input  logic                        out_ready_i
   ,input  logic [credit_width_lp-1:0]  out_credits_i
`ifdef BSG_MANYCORE_STORE_ISSUE_STATS_EN
   ,output logic [31:0]                 credit_stall_cnt_o
`endif
   );

   `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
   `DECLARE_BSG_MANYCORE_STORE_ENTRY_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

   localparam int entry_width_lp = $bits(bsg_manycore_store_entry_s);

   bsg_manycore_store_entry_s enq_entry, head_entry;
   logic [entry_width_lp-1:0] head_data;
   bsg_manycore_packet_s      packet;
   fence_state_e              state_reg;
   logic full, empty, enq, deq;
   logic up_reg, fence_busy_reg, fence_done_reg;
   logic credits_avail, credits_all_home;

   assign credits_avail    = (out_credits_i != '0);
   assign credits_all_home = (out_credits_i == credit_width_lp'(max_out_credits_p));

   // up_reg keeps ready_o low while reset is held and for the partial cycle
   // before the first clock edge after release.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) up_reg <= 1'b0;
      else            up_reg <= 1'b1;
   end

   assign ready_o = up_reg & (state_reg == e_fence_idle) & ~full & ~fence_i;
   assign out_v_o = ~empty & credits_avail;
   assign enq     = v_i & ready_o;
   assign deq     = out_v_o & out_ready_i;

   assign enq_entry.dest_y = dest_y_i;
   assign enq_entry.dest_x = dest_x_i;
   assign enq_entry.addr   = addr_i;
   assign enq_entry.data   = data_i;
   assign enq_entry.mask   = mask_i;

   bsg_manycore_store_issue_queue
     #(.width_p (entry_width_lp)
      ,.els_p   (fifo_els_p)
      ) queue
      (.clk_i     (clk_i)
      ,.reset_n_i (reset_n_i)
      ,.enq_i     (enq)
      ,.data_i    (enq_entry)
      ,.deq_i     (deq)
      ,.data_o    (head_data)
      ,.full_o    (full)
      ,.empty_o   (empty)
      );

   assign head_entry = head_data;

   always_comb begin
      packet            = '0;
      packet.addr       = head_entry.addr;
      packet.op         = e_remote_store;
      packet.op_ex      = head_entry.mask;
      packet.payload    = head_entry.data;
      packet.src_y_cord = my_y_i;
      packet.src_x_cord = my_x_i;
      packet.y_cord     = head_entry.dest_y;
      packet.x_cord     = head_entry.dest_x;
   end

   assign out_packet_o = packet;

   // Fence FSM; busy and done are registered alongside the state so that
   // done is seen in the first IDLE cycle after the credits return.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg      <= e_fence_idle;
         fence_busy_reg <= 1'b0;
         fence_done_reg <= 1'b0;
      end
      else begin
         fence_done_reg <= 1'b0;
         case (state_reg)
            e_fence_idle:
               if (fence_i) begin
                  state_reg      <= e_fence_drain;
                  fence_busy_reg <= 1'b1;
               end
            e_fence_drain:
               if (empty)
                  state_reg <= e_fence_wait_credits;
            e_fence_wait_credits:
               if (credits_all_home) begin
                  state_reg      <= e_fence_idle;
                  fence_busy_reg <= 1'b0;
                  fence_done_reg <= 1'b1;
               end
            default: begin
               state_reg      <= e_fence_idle;
               fence_busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign fence_busy_o = fence_busy_reg;
   assign fence_done_o = fence_done_reg;

`ifdef BSG_MANYCORE_STORE_ISSUE_STATS_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         stall_cnt_reg <= '0;
      else if (~empty & ~credits_avail & (stall_cnt_reg != '1))
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end

   assign credit_stall_cnt_o = stall_cnt_reg;
`endif

`ifndef SYNTHESIS
   assert property (@(posedge clk_i) disable iff (!reset_n_i) !(v_i & ready_o & full))
      else $error("store issue: request accepted while queue full");
   assert property (@(posedge clk_i) disable iff (!reset_n_i)
                    out_credits_i <= credit_width_lp'(max_out_credits_p))
      else $error("store issue: endpoint credit count above maximum");
`endif

endmodule

// File: tb/tb_bsg_manycore_store_issue.sv
module tb_bsg_manycore_store_issue;

   localparam int XW = 4, YW = 4, DW = 32, AW = 32, ELS = 2, MAXC = 4, CW = 3;
   localparam int MW = DW/8;
   localparam logic [XW-1:0] MY_X = 4'd3;
   localparam logic [YW-1:0] MY_Y = 4'd5;

   // Manycore packet layout, written out field by field.
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    op;
      logic [MW-1:0] op_ex;
      logic [DW-1:0] payload;
      logic [YW-1:0] src_y;
      logic [XW-1:0] src_x;
      logic [YW-1:0] dst_y;
      logic [XW-1:0] dst_x;
   } pkt_t;
   localparam int PW = $bits(pkt_t);

   typedef struct {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
   } req_t;

   typedef struct {
      req_t req;
      logic exp_ready;
      logic exp_out_v;
      pkt_t exp_pkt;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          v;
   logic [XW-1:0] dest_x, my_x;
   logic [YW-1:0] dest_y, my_y;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic [MW-1:0] mask;
   logic          ready, fence, fence_busy, fence_done;
   logic          out_v, out_ready;
   logic [PW-1:0] out_packet;
   logic [CW-1:0] credits;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bsg_manycore_store_issue #(
      .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
      .addr_width_p(AW), .fifo_els_p(ELS), .max_out_credits_p(MAXC)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .dest_x_i(dest_x),
      .dest_y_i(dest_y), .addr_i(addr), .data_i(data), .mask_i(mask),
      .ready_o(ready), .fence_i(fence), .fence_busy_o(fence_busy),
      .fence_done_o(fence_done), .my_x_i(my_x), .my_y_i(my_y),
      .out_v_o(out_v), .out_packet_o(out_packet), .out_ready_i(out_ready),
      .out_credits_i(credits)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic pkt_t mk_pkt(input req_t r);
      pkt_t p;
      p.addr    = r.addr;
      p.op      = 2'b01;
      p.op_ex   = r.mask;
      p.payload = r.data;
      p.src_y   = MY_Y;
      p.src_x   = MY_X;
      p.dst_y   = r.y;
      p.dst_x   = r.x;
      return p;
   endfunction

   function automatic req_t rnd_req();
      req_t r;
      r.x    = XW'($urandom);
      r.y    = YW'($urandom);
      r.addr = $urandom;
      r.data = $urandom;
      r.mask = MW'($urandom);
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
      else
         $display("ok   %s = %0h", name, act);
   endtask

   task automatic drive(input req_t r, input logic valid);
      v      = valid;
      dest_x = r.x;
      dest_y = r.y;
      addr   = r.addr;
      data   = r.data;
      mask   = r.mask;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   vec_t   vecs [4];
   req_t   r1, r2, r3, r4, r5, r6;
   req_t   model_q [$];
   req_t   rr;
   logic   rv, exp_ready, exp_v;

   initial begin
      // Table of single-store vectors; the first one is the basic store case.
      vecs[0].req = '{x: 4'd1, y: 4'd2, addr: 32'h40, data: 32'hDEADBEEF, mask: 4'hF};
      vecs[1].req = '{x: 4'hF, y: 4'h0, addr: 32'hFFFF_FFFC, data: 32'h0, mask: 4'h1};
      vecs[2].req = '{x: 4'h0, y: 4'hF, addr: 32'h0, data: 32'hFFFF_FFFF, mask: 4'h0};
      vecs[3].req = '{x: 4'h5, y: 4'hA, addr: 32'h1234_5678, data: 32'hA5A5_5A5A, mask: 4'h6};
      for (int i = 0; i < 4; i++) begin
         vecs[i].exp_ready = 1'b1;
         vecs[i].exp_out_v = 1'b1;
         vecs[i].exp_pkt   = mk_pkt(vecs[i].req);
      end

      reset_n = 1'b0; v = 1'b0; fence = 1'b0; out_ready = 1'b1; credits = 3'd4;
      dest_x = '0; dest_y = '0; addr = '0; data = '0; mask = '0;
      my_x = MY_X; my_y = MY_Y;

      // Reset state
      #3;
      chk("rst_ready", ready, 0);
      chk("rst_out_v", out_v, 0);
      chk("rst_busy", fence_busy, 0);
      chk("rst_done", fence_done, 0);
      #10;
      chk("rst_ready_held", ready, 0);
      reset_n = 1'b1;
      cyc();
      chk("ready_after_reset", ready, 1);

      // Table-driven single stores
      for (int i = 0; i < 4; i++) begin
         drive(vecs[i].req, 1'b1);
         mid();
         chk($sformatf("tbl%0d_ready", i), ready, vecs[i].exp_ready);
         chk($sformatf("tbl%0d_idle_out_v", i), out_v, 0);
         cyc();
         v = 1'b0;
         mid();
         chk($sformatf("tbl%0d_out_v", i), out_v, vecs[i].exp_out_v);
         chk($sformatf("tbl%0d_pkt", i), out_packet, vecs[i].exp_pkt);
         cyc();
      end

      // Credit starvation
      r1 = rnd_req(); r2 = rnd_req(); r3 = rnd_req();
      credits = 3'd0;
      drive(r1, 1'b1); mid(); chk("starve_ready1", ready, 1); cyc();
      drive(r2, 1'b1); mid(); chk("starve_ready2", ready, 1); chk("starve_out_v", out_v, 0); cyc();
      drive(r3, 1'b1); mid(); chk("starve_full_ready", ready, 0); chk("starve_full_out_v", out_v, 0); cyc();
      v = 1'b0; credits = 3'd1;
      mid(); chk("starve_launch_v", out_v, 1); chk("starve_launch_pkt", out_packet, mk_pkt(r1)); cyc();
      credits = 3'd4;
      mid(); chk("starve_ready_again", ready, 1); chk("starve_second_pkt", out_packet, mk_pkt(r2)); cyc();
      mid(); chk("starve_no_refused_entry", out_v, 0); cyc();

      // Backpressure
      r1 = rnd_req();
      out_ready = 1'b0;
      drive(r1, 1'b1); mid(); chk("bp_ready", ready, 1); cyc();
      v = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mid();
         chk($sformatf("bp_hold%0d_v", k), out_v, 1);
         chk($sformatf("bp_hold%0d_pkt", k), out_packet, mk_pkt(r1));
         cyc();
      end
      out_ready = 1'b1;
      mid(); chk("bp_launch_v", out_v, 1); chk("bp_launch_pkt", out_packet, mk_pkt(r1)); cyc();
      mid(); chk("bp_no_duplicate", out_v, 0); cyc();

      // Fence waiting on returning credits
      r1 = rnd_req(); r2 = rnd_req(); r3 = rnd_req();
      out_ready = 1'b0; credits = 3'd4;
      drive(r1, 1'b1); mid(); chk("fc_ready1", ready, 1); cyc();
      drive(r2, 1'b1); mid(); chk("fc_ready2", ready, 1); cyc();
      v = 1'b0; fence = 1'b1;
      mid(); chk("fc_busy_not_yet", fence_busy, 0); cyc();
      fence = 1'b0; out_ready = 1'b1;
      mid(); chk("fc_busy", fence_busy, 1); chk("fc_pkt1", out_packet, mk_pkt(r1)); cyc();
      credits = 3'd3;
      mid(); chk("fc_out_v2", out_v, 1); chk("fc_pkt2", out_packet, mk_pkt(r2)); cyc();
      credits = 3'd2;
      drive(r3, 1'b1);
      for (int k = 0; k < 3; k++) begin
         mid();
         chk($sformatf("fc_wait%0d_ready", k), ready, 0);
         chk($sformatf("fc_wait%0d_busy", k), fence_busy, 1);
         chk($sformatf("fc_wait%0d_done", k), fence_done, 0);
         cyc();
      end
      credits = 3'd3;
      mid(); chk("fc_c3_busy", fence_busy, 1); chk("fc_c3_done", fence_done, 0); cyc();
      credits = 3'd4;
      mid(); chk("fc_c4_done", fence_done, 0); chk("fc_c4_ready", ready, 0); cyc();
      mid(); chk("fc_done_pulse", fence_done, 1); chk("fc_busy_clear", fence_busy, 0);
      chk("fc_ready_back", ready, 1); cyc();
      v = 1'b0;
      mid(); chk("fc_done_one_cycle", fence_done, 0); chk("fc_pkt3", out_packet, mk_pkt(r3));
      chk("fc_out_v3", out_v, 1); cyc();

      // Request in the same cycle as fence_i; fence on an empty queue
      r4 = rnd_req();
      drive(r4, 1'b1); fence = 1'b1;
      mid(); chk("vf_refused", ready, 0); cyc();
      fence = 1'b0;
      mid(); chk("vf_drain_ready", ready, 0); chk("vf_drain_busy", fence_busy, 1); cyc();
      mid(); chk("vf_wait_ready", ready, 0); chk("vf_wait_done", fence_done, 0); cyc();
      mid(); chk("vf_done_at_3", fence_done, 1); chk("vf_ready", ready, 1); cyc();
      v = 1'b0;
      mid(); chk("vf_out_v", out_v, 1); chk("vf_pkt", out_packet, mk_pkt(r4));
      chk("vf_done_clear", fence_done, 0); cyc();

      // Asynchronous reset with two entries queued, mid-fence
      r5 = rnd_req(); r6 = rnd_req();
      out_ready = 1'b0;
      drive(r5, 1'b1); mid(); cyc();
      drive(r6, 1'b1); mid(); chk("ar_full_ready_src", ready, 1); cyc();
      v = 1'b0; fence = 1'b1; cyc();
      fence = 1'b0;
      mid(); chk("ar_pre_busy", fence_busy, 1); chk("ar_pre_out_v", out_v, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("ar_out_v", out_v, 0);
      chk("ar_busy", fence_busy, 0);
      chk("ar_ready", ready, 0);
      chk("ar_done", fence_done, 0);
      cyc(); cyc();
      reset_n = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mid();
         chk($sformatf("ar_post%0d_out_v", k), out_v, 0);
         chk($sformatf("ar_post%0d_done", k), fence_done, 0);
         cyc();
      end

      // Randomized traffic against a queue-based model
      model_q.delete();
      for (int n = 0; n < 400; n++) begin
         rr = rnd_req();
         rv = 1'($urandom_range(0, 1));
         drive(rr, rv);
         out_ready = ($urandom_range(0, 3) != 0);
         credits = ($urandom_range(0, 3) == 0) ? 3'd0 : CW'($urandom_range(1, MAXC));
         mid();
         exp_ready = (model_q.size() < ELS);
         exp_v     = (model_q.size() != 0) && (credits != 0);
         chk($sformatf("rnd%0d_ready", n), ready, exp_ready);
         chk($sformatf("rnd%0d_out_v", n), out_v, exp_v);
         if (exp_v)
            chk($sformatf("rnd%0d_pkt", n), out_packet, mk_pkt(model_q[0]));
         cyc();
         if (exp_v && out_ready)
            void'(model_q.pop_front());
         if (rv && exp_ready)
            model_q.push_back(rr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
